// File: rtl/breakout_btn_events.sv
// Breakout button event generator: debounced left/right/start levels to one-cycle game events.
// Optional macro BTN_ACCEL_EN: halves the auto-repeat interval after 8 repeat pulses while held.

module breakout_btn_dir #(
  parameter int REPEAT_DELAY = 500000,
  parameter int REPEAT_RATE  = 100000,
  parameter int CNT_W        = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic fire,
  output logic held
);

  // state  | meaning
  // IDLE   | button released, waiting for a rising edge
  // DELAY  | press pulse sent, counting down to the first auto-repeat
  // REPEAT | auto-repeating every REPEAT_RATE cycles (or faster with acceleration)
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DELAY_TC = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_TC  = CNT_W'(REPEAT_RATE - 1);

  state_t           state, state_nxt;
  logic             prev;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] interval_tc;

`ifdef BTN_ACCEL_EN
  localparam int               FAST_RATE = (REPEAT_RATE / 2 < 1) ? 1 : REPEAT_RATE / 2;
  localparam logic [CNT_W-1:0] FAST_TC   = CNT_W'(FAST_RATE - 1);

  // Counts pulses fired from REPEAT only; the first repeat comes out of DELAY,
  // so saturation at 7 means eight repeat pulses have been delivered.
  logic [2:0] rep_cnt, rep_cnt_nxt;

  assign interval_tc = (rep_cnt == 3'd7) ? FAST_TC : RATE_TC;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rep_cnt <= 3'd0;
    else        rep_cnt <= rep_cnt_nxt;
  end
`else
  assign interval_tc = RATE_TC;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      prev  <= 1'b0;
      held  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      prev  <= level;
      held  <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fire      = 1'b0;
`ifdef BTN_ACCEL_EN
    rep_cnt_nxt = rep_cnt;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = '0;
`ifdef BTN_ACCEL_EN
        rep_cnt_nxt = 3'd0;
`endif
        if (level && !prev) begin
          fire      = 1'b1;
          state_nxt = DELAY;
        end
      end
      DELAY: begin
        if (!level) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DELAY_TC) begin
          fire      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = REPEAT;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      REPEAT: begin
        // Release takes priority over a repeat due on the same cycle.
        if (!level) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == interval_tc) begin
          fire    = 1'b1;
          cnt_nxt = '0;
`ifdef BTN_ACCEL_EN
          if (rep_cnt != 3'd7) rep_cnt_nxt = rep_cnt + 3'd1;
`endif
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

module breakout_btn_events #(
  parameter int REPEAT_DELAY = 500000,
  parameter int REPEAT_RATE  = 100000,
  parameter int CNT_W        = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic left_in,
  input  logic right_in,
  input  logic start_in,
  output logic left_step,
  output logic right_step,
  output logic start_pulse,
  output logic left_held,
  output logic right_held
);

  logic left_fire;
  logic right_fire;
  logic start_prev;

  breakout_btn_dir #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .CNT_W       (CNT_W)
  ) u_left (
    .clk  (clk),
    .reset(reset),
    .level(left_in),
    .fire (left_fire),
    .held (left_held)
  );

  breakout_btn_dir #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .CNT_W       (CNT_W)
  ) u_right (
    .clk  (clk),
    .reset(reset),
    .level(right_in),
    .fire (right_fire),
    .held (right_held)
  );

  // Simultaneous left and right steps cancel; the FSMs keep their schedules.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_step   <= 1'b0;
      right_step  <= 1'b0;
      start_pulse <= 1'b0;
      start_prev  <= 1'b0;
    end else begin
      left_step   <= left_fire & ~right_fire;
      right_step  <= right_fire & ~left_fire;
      start_pulse <= start_in & ~start_prev;
      start_prev  <= start_in;
    end
  end

endmodule

// File: tb/tb_breakout_btn_events.sv
// Directed self-checking bench for breakout_btn_events (REPEAT_DELAY=10, REPEAT_RATE=4).
// Build with BTN_ACCEL_EN defined to check the accelerated repeat schedule.

module tb_breakout_btn_events;

  logic clk = 1'b0;
  logic reset;
  logic left_in, right_in, start_in;
  logic left_step, right_step, start_pulse, left_held, right_held;

  int checks = 0;
  int errors = 0;

`ifdef BTN_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  breakout_btn_events #(
    .REPEAT_DELAY(10),
    .REPEAT_RATE (4),
    .CNT_W       (20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .left_in    (left_in),
    .right_in   (right_in),
    .start_in   (start_in),
    .left_step  (left_step),
    .right_step (right_step),
    .start_pulse(start_pulse),
    .left_held  (left_held),
    .right_held (right_held)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_release();
    left_in  = 1'b0;
    right_in = 1'b0;
    start_in = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    left_in  = 1'b0;
    right_in = 1'b0;
    start_in = 1'b0;
    repeat (3) tick();
    checks++;
    if ({left_step, right_step, start_pulse, left_held, right_held} !== 5'b0) begin
      errors++;
      $display("FAIL reset_asserted: got %b exp 00000",
               {left_step, right_step, start_pulse, left_held, right_held});
    end
    #3 reset = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if ({left_step, right_step, start_pulse, left_held, right_held} !== 5'b0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got %b exp 00000", i,
                 {left_step, right_step, start_pulse, left_held, right_held});
      end
    end
  endtask

  task automatic test_hold();
    logic exp_step;
    left_in = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      exp_step = (i == 1) || (i >= 11 && (i - 11) % 4 == 0);
      checks++;
      if (left_step !== exp_step || right_step !== 1'b0 || left_held !== 1'b1) begin
        errors++;
        $display("FAIL hold cyc %0d: got step=%b rstep=%b held=%b exp step=%b rstep=0 held=1",
                 i, left_step, right_step, left_held, exp_step);
      end
    end
    // Edge 31 is where the next repeat would fire; release must win.
    left_in = 1'b0;
    tick();
    checks++;
    if (left_step !== 1'b0 || left_held !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: got step=%b held=%b exp step=0 held=0", left_step, left_held);
    end
    idle_release();
  endtask

  task automatic test_tap();
    logic lvl;
    for (int i = 1; i <= 20; i++) begin
      lvl     = (i == 1) || (i == 5);
      left_in = lvl;
      tick();
      checks++;
      if (left_step !== lvl || left_held !== lvl) begin
        errors++;
        $display("FAIL tap cyc %0d: got step=%b held=%b exp step=%b held=%b",
                 i, left_step, left_held, lvl, lvl);
      end
    end
    idle_release();
  endtask

  task automatic test_conflict();
    logic exp_r, exp_l;
    for (int i = 1; i <= 30; i++) begin
      right_in = 1'b1;
      left_in  = (i >= 15);
      tick();
      exp_r = (i == 1) || (i == 11) || (i == 19) || (i == 23) || (i == 27);
      exp_l = (i == 25) || (i == 29);
      checks++;
      if (right_step !== exp_r || left_step !== exp_l) begin
        errors++;
        $display("FAIL conflict cyc %0d: got l=%b r=%b exp l=%b r=%b",
                 i, left_step, right_step, exp_l, exp_r);
      end
    end
    checks++;
    if (left_held !== 1'b1 || right_held !== 1'b1) begin
      errors++;
      $display("FAIL conflict_held: got l=%b r=%b exp l=1 r=1", left_held, right_held);
    end
    idle_release();
  endtask

  task automatic test_start();
    start_in = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      checks++;
      if (start_pulse !== (i == 1) || left_step !== 1'b0 || right_step !== 1'b0) begin
        errors++;
        $display("FAIL start cyc %0d: got start=%b l=%b r=%b exp start=%b l=0 r=0",
                 i, start_pulse, left_step, right_step, (i == 1));
      end
    end
    start_in = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (start_pulse !== 1'b0) begin
        errors++;
        $display("FAIL start_release cyc %0d: got %b exp 0", i, start_pulse);
      end
    end
  endtask

  task automatic test_accel_hold();
    logic exp_step;
    left_in = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (i <= 39)
        exp_step = (i == 1) || (i >= 11 && (i - 11) % 4 == 0);
      else if (ACCEL)
        exp_step = ((i - 39) % 2 == 0);
      else
        exp_step = ((i - 11) % 4 == 0);
      checks++;
      if (left_step !== exp_step || left_held !== 1'b1) begin
        errors++;
        $display("FAIL long_hold cyc %0d: got step=%b held=%b exp step=%b held=1",
                 i, left_step, left_held, exp_step);
      end
    end
    idle_release();
  endtask

  task automatic test_reset_mid_hold();
    left_in  = 1'b1;
    right_in = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({left_step, right_step, start_pulse, left_held, right_held} !== 5'b0) begin
      errors++;
      $display("FAIL mid_reset_assert: got %b exp 00000",
               {left_step, right_step, start_pulse, left_held, right_held});
    end
    right_in = 1'b0;
    repeat (2) tick();
    #2 reset = 1'b1;
    tick();
    checks++;
    if (left_step !== 1'b1 || left_held !== 1'b1 || right_held !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_repress: got step=%b held=%b rheld=%b exp step=1 held=1 rheld=0",
               left_step, left_held, right_held);
    end
    for (int i = 2; i <= 10; i++) begin
      tick();
      checks++;
      if (left_step !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_delay cyc %0d: got %b exp 0", i, left_step);
      end
    end
    tick();
    checks++;
    if (left_step !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_first_repeat: got %b exp 1", left_step);
    end
    idle_release();
  endtask

  initial begin
    test_reset();
    test_hold();
    test_tap();
    test_conflict();
    test_start();
    test_accel_hold();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/breakout_btn_events.md
Name: breakout_btn_events

Overview:
Consumer side of the button debouncer: turns debounced level inputs (left, right, start) into single-cycle game events. Left/right produce paddle-step pulses, with auto-repeat while held. Start produces one pulse per press. Sits between the debouncer outputs and the game-control FSM; all outputs are registered.

Parameters:
REPEAT_DELAY, 500000, cycles from the press pulse to the first auto-repeat pulse (>=2)
REPEAT_RATE, 100000, cycles between consecutive auto-repeat pulses (>=2)
CNT_W, 20, counter width; must hold max(REPEAT_DELAY, REPEAT_RATE)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
left_in  input  1  debounced left level, 1 = pressed
right_in  input  1  debounced right level, 1 = pressed
start_in  input  1  debounced start level, 1 = pressed
left_step  output  1  one-cycle pulse: move paddle left
right_step  output  1  one-cycle pulse: move paddle right
start_pulse  output  1  one-cycle pulse on start press
left_held  output  1  left FSM not in IDLE (registered)
right_held  output  1  right FSM not in IDLE (registered)

Behaviour:
- Reset (reset=0, async): all outputs 0; prev-level regs 0; counters 0; FSMs IDLE.
- Rising edge = level sampled 1 at a clk edge while its prev reg holds 0. prev reg updates every cycle.
- An input held high through reset release gives a press event on the first edge after release.
- Latency: the press pulse is high for exactly the one cycle after the sampling edge that sees the rising edge.
- Per-direction FSM (left and right are independent, identical):
  - IDLE: on rising edge -> pulse, counter=0, go DELAY.
  - DELAY: level 0 -> IDLE, no pulse, counter=0. Otherwise counter++. When REPEAT_DELAY cycles have elapsed since the press pulse -> pulse, counter=0, go REPEAT.
  - REPEAT: level 0 -> IDLE, no pulse. Otherwise pulse every REPEAT_RATE cycles; counter resets at each pulse.
- Pulse spacing while held: press pulse at cycle t0; repeats at t0+REPEAT_DELAY, then +REPEAT_RATE each.
- Release on the same cycle a repeat would fire: release wins, no pulse.
- Release then re-press: restarts from IDLE with a fresh press pulse and full REPEAT_DELAY.
- left_held/right_held = 1 while the FSM is in DELAY or REPEAT, updated in the same cycle as the state.
- Conflict: if left_step and right_step would both assert in one cycle, both are suppressed. Both FSMs and counters keep running unaffected. A press that only one side generates is never suppressed.
- start: pulse on rising edge only; no repeat, no release event. Holding start gives exactly one pulse.
- Counters never wrap: in DELAY/REPEAT they are always cleared at or before their terminal count.
- Reset asserted mid-hold: immediate return to reset values. After release, a still-held input counts as a new press (one cycle after the first edge).

Optional Feature:
BTN_ACCEL_EN
- Defined: each direction keeps a 3-bit saturating repeat counter, cleared on entry to IDLE. After 8 repeat pulses in REPEAT, the interval becomes REPEAT_RATE/2 (integer divide, minimum 1) until release.
- Undefined: the interval is always REPEAT_RATE; no extra logic.

Test Plan:
(Bench params: REPEAT_DELAY=10, REPEAT_RATE=4.)
- Reset with all inputs 0, release, idle 20 cycles -> all outputs 0, held flags 0.
- left_in 0->1 at edge 5, held 30 cycles -> left_step pulses at cycles 6, 16, 20, 24, 28, 32. Each is 1 cycle wide. left_held=1 from cycle 6.
- left_in high 1 cycle, low 3, high again -> two press pulses 4 cycles apart, no repeat; left_held drops during the low gap.
- right_in held, left_in rises exactly on a right repeat cycle -> neither step asserts that cycle. Following right repeats stay on schedule (+4).
- start_in held 50 cycles -> exactly one start_pulse, 1 cycle after the rise.
- With BTN_ACCEL_EN: left held 60 cycles -> repeat spacing 4 for the first 8 repeats, then 2. Reset mid-hold clears everything; the re-press pulse comes 1 cycle after reset release.
